// File: rtl/div_pkg.sv
// Shared definitions for the vector divide sequencer and its result selector.
package div_pkg;

    // Default fixed-point format; must match the attached divider.
    localparam int DIV_N = 22;
    localparam int DIV_Q = 10;

    // Symmetric saturation limits: +(2^(N-1)-1) and -(2^(N-1)-1).
    localparam logic [DIV_N-1:0] MAX_POS = {1'b0, {(DIV_N-1){1'b1}}};
    localparam logic [DIV_N-1:0] MAX_NEG = {1'b1, {(DIV_N-2){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RDATA,
        ST_LAUNCH,
        ST_WAIT_DIV,
        ST_WRITE,
        ST_FINISH
    } seq_state_t;

    // Magnitude of a signed value in N-1 bits. The most negative value has no
    // N-1 bit magnitude, so it clamps to all ones; for the "quotient below one
    // LSB" comparison this gives the same answer as the exact magnitude,
    // because the shifted element is always a multiple of 2^Q.
    function automatic logic [DIV_N-2:0] abs_mag(input logic [DIV_N-1:0] v);
        logic [DIV_N-1:0] neg;
        neg = -v;
        if (!v[DIV_N-1]) begin
            return v[DIV_N-2:0];
        end
        if (neg[DIV_N-1]) begin
            return {(DIV_N-1){1'b1}};
        end
        return neg[DIV_N-2:0];
    endfunction

endpackage

// File: rtl/div_vec_sequencer_result_sel.sv
// Combinational mapping of divider status into the value written back.
module div_result_sel
    import div_pkg::*;
(
    input  logic             fast_zero,
    input  logic             elem_neg,
    input  logic             elem_zero,
    input  logic             divisor_neg,
    input  logic             dbz,
    input  logic             overflow,
    input  logic [DIV_N-1:0] div_q,
    output logic [DIV_N-1:0] result,
    output logic             sat
);

    // Priority: fast-path zero, then divide-by-zero, then overflow, else quotient.
    always_comb begin
        result = '0;
        sat    = 1'b0;
        if (fast_zero) begin
            result = '0;
        end else if (dbz) begin
            // 0/0 is written as 0 and not counted as a saturation.
            if (!elem_zero) begin
                result = elem_neg ? MAX_NEG : MAX_POS;
                sat    = 1'b1;
            end
        end else if (overflow) begin
            result = (elem_neg ^ divisor_neg) ? MAX_NEG : MAX_POS;
            sat    = 1'b1;
        end else begin
            result = div_q;
        end
    end

endmodule

// File: rtl/div_vec_sequencer.sv
// Walks a buffer vector, divides each element by a shared divisor through an
// external divider and writes the sanitised quotients to a destination region.
module div_vec_sequencer
    import div_pkg::*;
#(
    parameter int N      = DIV_N,
    parameter int Q      = DIV_Q,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] len,
    input  logic [N-1:0]      divisor,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sat_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [N-1:0]      rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [N-1:0]      wr_data,
    output logic              div_start,
    output logic [N-1:0]      div_dividend,
    output logic [N-1:0]      div_divisor,
    input  logic              div_done,
    input  logic              div_dbz,
    input  logic              div_overflow,
    input  logic [N-1:0]      div_q
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    seq_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] src_base_reg, dst_base_reg, len_reg, index_reg;
    logic [ADDR_W-1:0] sat_count_reg;
    logic [N-1:0]      divisor_reg, elem_reg, result_reg;
    logic              first_wait_reg;

    logic [N-2:0]      rd_abs, div_abs;
    logic [N+Q-1:0]    elem_scaled, divisor_ext;
    logic              fast_hit;
    logic              div_accept;
    logic [N-1:0]      sel_result;
    logic              sel_sat;

    // Fast path: the quotient is below one LSB, so the divider is skipped.
    always_comb begin
        rd_abs      = abs_mag(rd_data);
        div_abs     = abs_mag(divisor_reg);
        elem_scaled = {1'b0, rd_abs, {Q{1'b0}}};
        divisor_ext = {{(Q+1){1'b0}}, div_abs};
        fast_hit    = (state_reg == ST_RDATA) && (divisor_reg != '0)
                      && (elem_scaled < divisor_ext);
        // The first WAIT_DIV cycle may still see the previous element's done level.
        div_accept  = (state_reg == ST_WAIT_DIV) && !first_wait_reg && div_done;
    end

    div_result_sel u_result_sel (
        .fast_zero   (fast_hit),
        .elem_neg    (elem_reg[N-1]),
        .elem_zero   (elem_reg == '0),
        .divisor_neg (divisor_reg[N-1]),
        .dbz         (div_dbz),
        .overflow    (div_overflow),
        .div_q       (div_q),
        .result      (sel_result),
        .sat         (sel_sat)
    );

    // State register and per-job datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            src_base_reg   <= '0;
            dst_base_reg   <= '0;
            len_reg        <= '0;
            index_reg      <= '0;
            sat_count_reg  <= '0;
            divisor_reg    <= '0;
            elem_reg       <= '0;
            result_reg     <= '0;
            first_wait_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        src_base_reg  <= src_base;
                        dst_base_reg  <= dst_base;
                        len_reg       <= len;
                        divisor_reg   <= divisor;
                        index_reg     <= '0;
                        sat_count_reg <= '0;
                    end
                end
                ST_RDATA: begin
                    elem_reg <= rd_data;
                    if (fast_hit) begin
                        result_reg <= sel_result;
                    end
                end
                ST_LAUNCH: begin
                    first_wait_reg <= 1'b1;
                end
                ST_WAIT_DIV: begin
                    first_wait_reg <= 1'b0;
                    if (div_accept) begin
                        result_reg <= sel_result;
                        if (sel_sat) begin
                            sat_count_reg <= sat_count_reg + ONE;
                        end
                    end
                end
                ST_WRITE: begin
                    index_reg <= index_reg + ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        div_start  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? ST_FINISH : ST_READ;
                end
            end
            ST_READ: begin
                busy       = 1'b1;
                rd_en      = 1'b1;
                rd_addr    = src_base_reg + index_reg;
                state_next = ST_RDATA;
            end
            ST_RDATA: begin
                busy       = 1'b1;
                state_next = fast_hit ? ST_WRITE : ST_LAUNCH;
            end
            ST_LAUNCH: begin
                busy       = 1'b1;
                div_start  = 1'b1;
                state_next = ST_WAIT_DIV;
            end
            ST_WAIT_DIV: begin
                busy = 1'b1;
                if (div_accept) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy       = 1'b1;
                wr_en      = 1'b1;
                wr_addr    = dst_base_reg + index_reg;
                wr_data    = result_reg;
                state_next = ((index_reg + ONE) == len_reg) ? ST_FINISH : ST_READ;
            end
            ST_FINISH: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign sat_count    = sat_count_reg;
    assign div_dividend = elem_reg;
    assign div_divisor  = divisor_reg;

endmodule

// File: tb/tb_div_vec_sequencer.sv
// Self-checking bench for div_vec_sequencer with a buffer and divider model.
module tb_div_vec_sequencer;

    localparam int N     = 22;
    localparam int AW    = 10;
    localparam int MAXV  = 2097151;
    localparam int DLAT  = 34;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [AW-1:0]        src_base = '0, dst_base = '0, len = '0;
    logic signed [N-1:0]  divisor = '0;
    logic                 busy, done, rd_en, wr_en, div_start;
    logic [AW-1:0]        sat_count, rd_addr, wr_addr;
    logic signed [N-1:0]  rd_data = '0;
    logic signed [N-1:0]  wr_data, div_dividend, div_divisor;
    logic                 div_done = 1'b0, div_dbz = 1'b0, div_overflow = 1'b0;
    logic signed [N-1:0]  div_q = '0;

    logic signed [N-1:0]  mem [0:1023];

    int n_chk = 0, n_err = 0;
    int n_start = 0, n_done = 0, n_wr = 0, n_rd = 0, n_both = 0, n_unstable = 0;
    int stall = 0;
    int cnt = 0;
    longint cap_a = 0, cap_b = 0;

    always #5 clk = ~clk;

    div_vec_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
        .len(len), .divisor(divisor), .busy(busy), .done(done), .sat_count(sat_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .div_start(div_start),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_done(div_done),
        .div_dbz(div_dbz), .div_overflow(div_overflow), .div_q(div_q)
    );

    // Activation buffer: one-cycle read latency.
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] = wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Event counters.
    always @(negedge clk) begin
        if (div_start) n_start++;
        if (done) n_done++;
        if (wr_en) n_wr++;
        if (rd_en) n_rd++;
        if (rd_en && wr_en) n_both++;
    end

    // Divider model: fixed latency plus optional stall, done is a level,
    // quotient left stale when it would be zero.
    always @(negedge clk) begin
        longint q;
        if (div_start) begin
            cap_a = div_dividend;
            cap_b = div_divisor;
            cnt = DLAT + stall;
            div_done = 1'b0;
            div_dbz = 1'b0;
            div_overflow = 1'b0;
        end else if (cnt > 0) begin
            if (busy && !rst && (longint'(div_dividend) != cap_a || longint'(div_divisor) != cap_b))
                n_unstable++;
            cnt--;
            if (cnt == 0) begin
                if (cap_b == 0) begin
                    div_dbz = 1'b1;
                end else begin
                    q = (cap_a * 1024) / cap_b;
                    if (q > MAXV || q < -MAXV - 1) div_overflow = 1'b1;
                    else if (q != 0) div_q = N'(q);
                end
                div_done = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit is_fast(input int e, input int d);
        return (d != 0) && (absl(e) * 1024 < absl(d));
    endfunction

    // Reference: ideal quotient e*2^10/d truncated, with saturation rules.
    function automatic int ref_div(input int e, input int d, output int sat);
        longint q;
        sat = 0;
        if (is_fast(e, d)) return 0;
        if (d == 0) begin
            if (e == 0) return 0;
            sat = 1;
            return (e > 0) ? MAXV : -MAXV;
        end
        q = (longint'(e) * 1024) / longint'(d);
        if (q > MAXV || q < -MAXV - 1) begin
            sat = 1;
            return ((e < 0) != (d < 0)) ? -MAXV : MAXV;
        end
        return int'(q);
    endfunction

    task automatic kick(input int src, input int dst, input int ln, input int d);
        @(negedge clk);
        src_base = AW'(src);
        dst_base = AW'(dst);
        len = AW'(ln);
        divisor = N'(d);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int limit, output int lat);
        lat = 0;
        while (!done && lat < limit) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk({nm, "_timeout"}, 1, 0);
        @(negedge clk);
    endtask

    typedef struct {
        int src; int dst; int len; int d;
        int e[8]; int x[8];
        int sat; int starts; int stl; int poke;
    } vec_t;

    vec_t vecs[6];

    task automatic run_job(input string nm, input vec_t v);
        int s0, d0, lat;
        for (int i = 0; i < v.len; i++) mem[(v.src + i) % 1024] = N'(v.e[i]);
        stall = v.stl;
        s0 = n_start;
        d0 = n_done;
        kick(v.src, v.dst, v.len, v.d);
        if (v.poke != 0) begin
            repeat (5) @(negedge clk);
            src_base = AW'(900);
            len = AW'(1);
            divisor = N'(7);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(nm, v.len * (40 + v.stl) + 20, lat);
        for (int i = 0; i < v.len; i++)
            chk($sformatf("%s_elem%0d", nm, i), mem[(v.dst + i) % 1024], v.x[i]);
        chk({nm, "_sat_count"}, sat_count, v.sat);
        chk({nm, "_div_starts"}, n_start - s0, v.starts);
        chk({nm, "_done_pulses"}, n_done - d0, 1);
        if (v.poke != 0) begin
            repeat (10) @(negedge clk);
            chk({nm, "_idle_after"}, busy, 0);
        end
        stall = 0;
        $display("job %s: len=%0d divisor=%0d sat=%0d starts=%0d cycles=%0d",
                 nm, v.len, v.d, sat_count, n_start - s0, lat);
    endtask

    initial begin
        int s0, d0, w0, r0, lat;
        vec_t rv;
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        vecs[0] = '{0, 16, 4, 2048, '{1024, -3072, 0, 1, 0, 0, 0, 0},
                    '{512, -1536, 0, 0, 0, 0, 0, 0}, 0, 2, 0, 0};
        vecs[1] = '{32, 48, 2, 1, '{1048576, -1048576, 0, 0, 0, 0, 0, 0},
                    '{2097151, -2097151, 0, 0, 0, 0, 0, 0}, 2, 2, 0, 0};
        vecs[2] = '{80, 96, 3, 0, '{5, -5, 0, 0, 0, 0, 0, 0},
                    '{2097151, -2097151, 0, 0, 0, 0, 0, 0}, 2, 3, 0, 0};
        vecs[3] = '{128, 128, 3, -1024, '{100, -2097152, 7, 0, 0, 0, 0, 0},
                    '{-100, 2097151, -7, 0, 0, 0, 0, 0}, 1, 3, 0, 0};
        vecs[4] = '{160, 176, 4, 3000, '{3000, -4000, 5000, -6000, 0, 0, 0, 0},
                    '{1024, -1365, 1706, -2048, 0, 0, 0, 0}, 0, 4, 10, 1};
        vecs[5] = '{1022, 300, 3, 1024, '{10, -20, 30, 0, 0, 0, 0, 0},
                    '{10, -20, 30, 0, 0, 0, 0, 0}, 0, 3, 0, 0};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_outputs", |{busy, done, rd_en, wr_en, div_start, sat_count, rd_addr,
                               wr_addr, wr_data, div_dividend, div_divisor}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int k = 0; k < 6; k++) run_job($sformatf("vec%0d", k), vecs[k]);

        // Empty job: done only, no memory or divider traffic.
        s0 = n_start; d0 = n_done; w0 = n_wr; r0 = n_rd;
        kick(500, 510, 0, 5);
        wait_done("len0", 10, lat);
        chk("len0_latency", lat, 0);
        chk("len0_done_pulses", n_done - d0, 1);
        chk("len0_traffic", (n_start - s0) + (n_wr - w0) + (n_rd - r0), 0);
        $display("job len0: cycles=%0d", lat);

        // Reset during the divider wait of the second element.
        for (int i = 0; i < 4; i++) begin
            mem[200 + i] = N'(4096 * (i + 1));
            mem[220 + i] = N'(12345);
        end
        s0 = n_start; w0 = n_wr;
        kick(200, 220, 4, 2048);
        lat = 0;
        while (n_start - s0 < 2 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("rst_reach_elem2", n_start - s0, 2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_midjob_outputs", |{busy, done, rd_en, wr_en, div_start, sat_count, rd_addr,
                                    wr_addr, wr_data, div_dividend, div_divisor}, 0);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("rst_writes", n_wr - w0, 1);
        chk("rst_starts", n_start - s0, 2);
        chk("rst_elem0", mem[220], 2048);
        chk("rst_elem1_untouched", mem[221], 12345);
        $display("job reset_abort: writes=%0d starts=%0d", n_wr - w0, n_start - s0);

        // Randomised jobs against the reference model.
        for (int j = 0; j < 10; j++) begin
            int s;
            rv.len = $urandom_range(1, 6);
            rv.src = 400 + j * 16;
            rv.dst = (j % 2 == 1) ? rv.src : 700 + j * 16;
            case ($urandom_range(0, 4))
                0: rv.d = 0;
                1: rv.d = int'($urandom_range(1, 20)) * ((j % 3 == 0) ? -1 : 1);
                2: rv.d = int'($urandom_range(1024, 8192)) * ((j % 2 == 0) ? -1 : 1);
                default: rv.d = int'($urandom_range(0, 4194303)) - 2097152;
            endcase
            rv.sat = 0;
            rv.starts = 0;
            rv.stl = $urandom_range(0, 5);
            rv.poke = 0;
            for (int i = 0; i < 8; i++) begin
                rv.e[i] = 0;
                rv.x[i] = 0;
            end
            for (int i = 0; i < rv.len; i++) begin
                case ($urandom_range(0, 4))
                    0: rv.e[i] = 0;
                    1: rv.e[i] = int'($urandom_range(0, 63)) - 32;
                    2: rv.e[i] = int'($urandom_range(0, 8191)) - 4096;
                    3: rv.e[i] = ($urandom_range(0, 1) == 1) ? -2097152 : 2097151;
                    default: rv.e[i] = int'($urandom_range(0, 4194303)) - 2097152;
                endcase
                rv.x[i] = ref_div(rv.e[i], rv.d, s);
                rv.sat += s;
                if (!is_fast(rv.e[i], rv.d)) rv.starts++;
            end
            run_job($sformatf("rand%0d", j), rv);
        end

        chk("rd_wr_same_cycle", n_both, 0);
        chk("div_operands_stable", n_unstable, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
